// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared op encodings, trial FSM states and count-width helper
//   CA_OP_INIT/DOIT/HOLD : cell-array command codes on the op bus
//   ca_trial_state_e     : trial controller FSM states
//   ca_cnt_w(n)          : bits needed to hold a ones-count of 0..n
package ca_pkg;

    localparam logic [1:0] CA_OP_INIT = 2'd0;
    localparam logic [1:0] CA_OP_DOIT = 2'd1;
    localparam logic [1:0] CA_OP_HOLD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } ca_trial_state_e;

    function automatic int ca_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ca_popcount.sv
// rtl/ca_popcount.sv - combinational ones-counter
//   W     : number of input bits
//   CW    : width of the count output
//   bits  : input vector
//   count : number of ones in bits
module ca_popcount #(
    parameter int W  = 60,
    parameter int CW = 6
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/ca_trial_ctrl.sv
// rtl/ca_trial_ctrl.sv - density-classification trial run controller and judge
//   clk, reset          : clock, asynchronous active-high reset
//   start, seed_in      : trial request and its seed (sampled in IDLE/DONE)
//   ca_state            : cell array state vector, one generation per cycle
//   op, ca_in           : registered array command and seed bits
//   busy, done          : trial in progress / trial finished (level)
//   converged, pass, tie: verdict flags
//   steps_used          : generation at which the trial ended
//   trials, passes      : saturating trial statistics (only with CA_TRIAL_STATS_EN)
module ca_trial_ctrl
    import ca_pkg::*;
#(
    parameter int CA_WIDTH  = 60,
    parameter int MAX_STEPS = 100,
    parameter int STEP_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CA_WIDTH-1:0] seed_in,
    input  logic [CA_WIDTH-1:0] ca_state,
    output logic [1:0]          op,
    output logic [CA_WIDTH-1:0] ca_in,
    output logic                busy,
    output logic                done,
    output logic                converged,
    output logic                pass,
    output logic                tie,
`ifdef CA_TRIAL_STATS_EN
    output logic [15:0]         trials,
    output logic [15:0]         passes,
`endif
    output logic [STEP_W-1:0]   steps_used
);

    localparam int                CW      = ca_cnt_w(CA_WIDTH);
    localparam logic [CW-1:0]     HALF    = CW'(CA_WIDTH / 2);
    localparam logic [STEP_W-1:0] GEN_MAX = STEP_W'(MAX_STEPS);
    localparam bit                EVEN_W  = (CA_WIDTH % 2) == 0;

    ca_trial_state_e   state;
    logic [STEP_W-1:0] gen;
    logic              maj;
    logic [CW-1:0]     ones;
    logic              seed_maj;
    logic              seed_tie;
    logic              uniform;
    logic              verdict_pass;

    ca_popcount #(
        .W  (CA_WIDTH),
        .CW (CW)
    ) u_popcount (
        .bits  (seed_in),
        .count (ones)
    );

    assign seed_maj     = ones > HALF;
    // An odd-width array can never split evenly, so it never ties.
    assign seed_tie     = EVEN_W && (ones == HALF);
    assign uniform      = (ca_state == '0) || (ca_state == '1);
    assign verdict_pass = (ca_state[0] == maj) && !tie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op         <= CA_OP_HOLD;
            ca_in      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            pass       <= 1'b0;
            tie        <= 1'b0;
            steps_used <= '0;
            gen        <= '0;
            maj        <= 1'b0;
`ifdef CA_TRIAL_STATS_EN
            trials     <= '0;
            passes     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ca_in     <= seed_in;
                        maj       <= seed_maj;
                        tie       <= seed_tie;
                        done      <= 1'b0;
                        converged <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        op        <= CA_OP_INIT;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    op    <= CA_OP_DOIT;
                    gen   <= '0;
                    state <= ST_WAIT;
                end
                // The array output lags its load by one cycle; skip that sample.
                ST_WAIT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (uniform) begin
                        converged  <= 1'b1;
                        pass       <= verdict_pass;
                        steps_used <= gen;
                        op         <= CA_OP_HOLD;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
`ifdef CA_TRIAL_STATS_EN
                        if (trials != 16'hFFFF) trials <= trials + 16'd1;
                        if (verdict_pass && passes != 16'hFFFF) passes <= passes + 16'd1;
`endif
                    end else if (gen == GEN_MAX) begin
                        converged  <= 1'b0;
                        pass       <= 1'b0;
                        steps_used <= GEN_MAX;
                        op         <= CA_OP_HOLD;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
`ifdef CA_TRIAL_STATS_EN
                        if (trials != 16'hFFFF) trials <= trials + 16'd1;
`endif
                    end else begin
                        gen <= gen + STEP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    op    <= CA_OP_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ca_trial_ctrl.sv
// tb/tb_ca_trial_ctrl.sv - directed self-checking bench for ca_trial_ctrl
module tb_ca_trial_ctrl;
    import ca_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  seed_in = 8'h00;
    logic [7:0]  ca_state = 8'h00;
    logic [7:0]  cells = 8'h00;

    logic [1:0]  op_a, op_b;
    logic [7:0]  ca_in_a, ca_in_b;
    logic        busy_a, done_a, conv_a, pass_a, tie_a;
    logic        busy_b, done_b, conv_b, pass_b, tie_b;
    logic [15:0] steps_a, steps_b;
`ifdef CA_TRIAL_STATS_EN
    logic [15:0] trials_a, passes_a, trials_b, passes_b;
`endif

    int errors = 0;
    int checks = 0;

    // Array model: cells update on posedge, state output lags by one register.
    logic       sel = 1'b0;
    logic [7:0] script [0:7];
    int         idx = 0;
    logic [1:0] mop;
    logic [7:0] mca_in;
    assign mop    = sel ? op_b : op_a;
    assign mca_in = sel ? ca_in_b : ca_in_a;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ca_state <= cells;
        if (mop == CA_OP_INIT) begin
            cells <= mca_in;
            idx   <= 0;
        end else if (mop == CA_OP_DOIT) begin
            cells <= script[idx];
            if (idx < 7) idx <= idx + 1;
        end
    end

    ca_trial_ctrl #(.CA_WIDTH(8), .MAX_STEPS(4), .STEP_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
        .ca_state(ca_state), .op(op_a), .ca_in(ca_in_a), .busy(busy_a),
        .done(done_a), .converged(conv_a), .pass(pass_a), .tie(tie_a),
`ifdef CA_TRIAL_STATS_EN
        .trials(trials_a), .passes(passes_a),
`endif
        .steps_used(steps_a)
    );

    ca_trial_ctrl #(.CA_WIDTH(8), .MAX_STEPS(8), .STEP_W(16)) dut_long (
        .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
        .ca_state(ca_state), .op(op_b), .ca_in(ca_in_b), .busy(busy_b),
        .done(done_b), .converged(conv_b), .pass(pass_b), .tie(tie_b),
`ifdef CA_TRIAL_STATS_EN
        .trials(trials_b), .passes(passes_b),
`endif
        .steps_used(steps_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entry 0 (MSB byte) is generation 1.
    task automatic set_script(input logic [63:0] s);
        for (int i = 0; i < 8; i++) script[i] = s[63-8*i -: 8];
    endtask

    // Starts a trial on dut at edge T, keeps start high through edge T+hold,
    // returns k such that done was first seen after edge T+k (-1 if never),
    // and the number of cycles after gen 0 was sampled with op = DOIT.
    task automatic run_trial(input logic [7:0] seed, input int hold,
                             output int lat, output int doit_cnt);
        @(negedge clk);
        seed_in = seed;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        lat      = -1;
        doit_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c >= hold) start = 1'b0;
            if (c >= 3 && op_a == CA_OP_DOIT) doit_cnt++;
            if (done_a) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    int lat, dc;

    initial begin
        set_script(64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_op", op_a, CA_OP_HOLD);
        check("rst_ca_in", ca_in_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_conv", conv_a, 1'b0);
        check("rst_pass", pass_a, 1'b0);
        check("rst_tie", tie_a, 1'b0);
        check("rst_steps", steps_a, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-trial at gen 5 on the long-budget instance.
        sel = 1'b1;
        set_script(64'h55AA55AA55AA55AA);
        @(negedge clk);
        seed_in = 8'hAA;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy_before", busy_b, 1'b1);
        check("mid_op_before", op_b, CA_OP_DOIT);
        reset = 1'b1;
        #1;
        check("mid_rst_op", op_b, CA_OP_HOLD);
        check("mid_rst_busy", busy_b, 1'b0);
        check("mid_rst_done", done_b, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sel   = 1'b0;

        // Majority ones, classified correctly.
        set_script(64'hFEFFFFFFFFFFFFFF);
        run_trial(8'hEC, 0, lat, dc);
        check("maj_lat", lat, 5);
        check("maj_conv", conv_a, 1'b1);
        check("maj_pass", pass_a, 1'b1);
        check("maj_steps", steps_a, 16'd2);
        check("maj_tie", tie_a, 1'b0);
        check("maj_busy", busy_a, 1'b0);
        check("maj_op", op_a, CA_OP_HOLD);
        check("maj_ca_in", ca_in_a, 8'hEC);

        // Wrong classification.
        set_script(64'hFE7E000000000000);
        run_trial(8'hEC, 0, lat, dc);
        check("wrong_lat", lat, 6);
        check("wrong_conv", conv_a, 1'b1);
        check("wrong_pass", pass_a, 1'b0);
        check("wrong_steps", steps_a, 16'd3);

        // Timeout on an oscillating pattern.
        set_script(64'h55AA55AA55AA55AA);
        run_trial(8'hAA, 0, lat, dc);
        check("tmo_lat", lat, 7);
        check("tmo_conv", conv_a, 1'b0);
        check("tmo_pass", pass_a, 1'b0);
        check("tmo_steps", steps_a, 16'd4);
        check("tmo_doit", dc, 4);
        check("tmo_tie", tie_a, 1'b1);

        // Tie seed converging to all ones.
        set_script(64'hFFFFFFFFFFFFFFFF);
        run_trial(8'h0F, 0, lat, dc);
        check("tie_lat", lat, 4);
        check("tie_tie", tie_a, 1'b1);
        check("tie_pass", pass_a, 1'b0);
        check("tie_conv", conv_a, 1'b1);
        check("tie_steps", steps_a, 16'd1);

        // Fresh reset so the statistics count only the next two trials.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // start held through RUN must not restart the trial.
        set_script(64'hFE7E000000000000);
        run_trial(8'hEC, 5, lat, dc);
        check("hold_lat", lat, 6);
        check("hold_steps", steps_a, 16'd3);
        check("hold_pass", pass_a, 1'b0);
        check("hold_conv", conv_a, 1'b1);

        // Uniform seed started directly from DONE.
        set_script(64'h0);
        run_trial(8'h00, 0, lat, dc);
        check("zero_lat", lat, 3);
        check("zero_steps", steps_a, 16'd0);
        check("zero_pass", pass_a, 1'b1);
        check("zero_conv", conv_a, 1'b1);
        check("zero_tie", tie_a, 1'b0);
`ifdef CA_TRIAL_STATS_EN
        check("stat_trials", trials_a, 16'd2);
        check("stat_passes", passes_a, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
